// File: rtl/hevc_interp8_ms.sv
// hevc_interp8_ms: multi-flow HEVC luma 8-tap separable interpolation.
// Per-flow config, pixel FIFO, filter core and result FIFO; round-robin tagged output.
module hevc_interp8_ms #(
  parameter int DEPTH   = 16,
  parameter int FLUX    = 2,
  parameter int MAX_EXT = 71,
  localparam int TW = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TW+2:0]   v_alpha_din,
  input  logic            v_alpha_write,
  output logic [FLUX-1:0] v_alpha_full,
  input  logic [TW+2:0]   h_alpha_din,
  input  logic            h_alpha_write,
  output logic [FLUX-1:0] h_alpha_full,
  input  logic [TW+6:0]   ext_size_din,
  input  logic            ext_size_write,
  output logic [FLUX-1:0] ext_size_full,
  input  logic [TW+7:0]   in_din,
  input  logic            in_write,
  output logic [FLUX-1:0] in_full,
  output logic [TW+7:0]   out_din,
  output logic            out_write,
  input  logic [FLUX-1:0] out_full
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  // Taps packed c7..c0, two's complement bytes
  function automatic logic [63:0] coefs(input logic [2:0] a);
    case (a)
      3'd2:    coefs = 64'h0001FB113AF604FF;
      3'd4:    coefs = 64'hFF04F52828F504FF;
      3'd6:    coefs = 64'hFF04F63A11FB0100;
      default: coefs = 64'h0000000040000000;
    endcase
  endfunction

  logic [FLUX-1:0] res_req;
  logic [FLUX-1:0] req;
  logic [FLUX-1:0] grant;
  logic [7:0]      res_head [FLUX];
  logic [TW-1:0]   last;
  logic [TW-1:0]   gid;
  logic            found;

  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    localparam logic [TW-1:0] FID = TW'(f);
    st_t st, st_n;
    logic [2:0]  va, ha;
    logic [6:0]  ext, size, pr, pc;
    logic        va_s, ha_s, ext_s;
    logic        va_wr, ha_wr, ext_wr, in_wr, ext_ok;
    logic [7:0]  fm [DEPTH];
    logic [AW-1:0] frp, fwp;
    logic [AW:0] fcnt;
    logic [7:0]  rm [4];
    logic [1:0]  rrp, rwp;
    logic [2:0]  rcnt;
    logic [12:0] ecnt, total;
    logic        done_pop, room, pop, push;
    logic [7:0]  hsr [8];
    logic        a_v, a_emit, b_v, b_emit;
    logic [6:0]  a_x, a_r, b_x;
    logic signed [15:0] hacc, h_q;
    logic signed [15:0] lb [MAX_EXT][7];
    logic signed [27:0] vacc, vrnd;
    logic [7:0]  pix;
    logic [63:0] hco, vco;

    assign v_alpha_full[f]  = !(st == IDLE && !va_s);
    assign h_alpha_full[f]  = !(st == IDLE && !ha_s);
    assign ext_size_full[f] = !(st == IDLE && !ext_s);
    assign in_full[f]       = (fcnt == (AW+1)'(DEPTH));

    assign va_wr  = v_alpha_write && v_alpha_din[TW+2 -: TW] == FID
                    && !v_alpha_full[f];
    assign ha_wr  = h_alpha_write && h_alpha_din[TW+2 -: TW] == FID
                    && !h_alpha_full[f];
    assign ext_wr = ext_size_write && ext_size_din[TW+6 -: TW] == FID
                    && !ext_size_full[f];
    assign ext_ok = ext_size_din[6:0] >= 7'd8
                    && ext_size_din[6:0] <= 7'(MAX_EXT);
    assign in_wr  = in_write && in_din[TW+7 -: TW] == FID && !in_full[f];

    assign size  = ext - 7'd7;
    assign total = 13'(size) * 13'(size);
    // Credit covers both pipeline stages so a pop always has a slot
    assign room  = ({1'b0, rcnt} + 4'(a_v) + 4'(b_v)) < 4'd4;
    assign pop   = st == RUN && fcnt != '0 && room && !done_pop;
    assign push  = b_v && b_emit;
    assign hco   = coefs(ha);
    assign vco   = coefs(va);

    assign res_req[f]  = rcnt != 3'd0;
    assign res_head[f] = rm[rrp];

    always_comb begin
      st_n = st;
      unique case (st)
        IDLE:    if (va_s && ha_s && ext_s) st_n = RUN;
        RUN:     if (ecnt == total) st_n = DONE;
        DONE:    st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end

    always_comb begin
      hacc = '0;
      for (int k = 0; k < 8; k++)
        hacc = hacc + 16'($signed(hco[8*k +: 8]))
                    * 16'($signed({1'b0, hsr[k]}));
    end

    always_comb begin
      vacc = 28'($signed(vco[63:56])) * 28'(h_q);
      for (int j = 0; j < 7; j++)
        vacc = vacc + 28'($signed(vco[8*j +: 8])) * 28'(lb[b_x][j]);
      vrnd = ((vacc >>> 6) + 28'sd32) >>> 6;
      if (vrnd < 28'sd0)
        pix = 8'd0;
      else if (vrnd > 28'sd255)
        pix = 8'd255;
      else
        pix = vrnd[7:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st <= IDLE;
        va <= '0; ha <= '0; ext <= '0;
        va_s <= 1'b0; ha_s <= 1'b0; ext_s <= 1'b0;
        frp <= '0; fwp <= '0; fcnt <= '0;
        rrp <= '0; rwp <= '0; rcnt <= '0;
        pr <= '0; pc <= '0; done_pop <= 1'b0; ecnt <= '0;
        a_v <= 1'b0; a_emit <= 1'b0; a_x <= '0; a_r <= '0;
        b_v <= 1'b0; b_emit <= 1'b0; b_x <= '0;
      end else begin
        st <= st_n;
        if (va_wr) begin
          va <= v_alpha_din[2:0];
          va_s <= 1'b1;
        end
        if (ha_wr) begin
          ha <= h_alpha_din[2:0];
          ha_s <= 1'b1;
        end
        if (ext_wr && ext_ok) begin
          ext <= ext_size_din[6:0];
          ext_s <= 1'b1;
        end
        if (st == DONE) begin
          va_s <= 1'b0; ha_s <= 1'b0; ext_s <= 1'b0;
        end
        if (in_wr)
          fwp <= (fwp == AW'(DEPTH-1)) ? '0 : fwp + 1'b1;
        if (pop)
          frp <= (frp == AW'(DEPTH-1)) ? '0 : frp + 1'b1;
        fcnt <= fcnt + (AW+1)'(in_wr) - (AW+1)'(pop);
        if (st == IDLE) begin
          pr <= '0; pc <= '0; done_pop <= 1'b0; ecnt <= '0;
        end else begin
          if (pop) begin
            if (pc == ext - 7'd1) begin
              pc <= '0;
              pr <= pr + 7'd1;
              if (pr == ext - 7'd1) done_pop <= 1'b1;
            end else begin
              pc <= pc + 7'd1;
            end
          end
          if (grant[f]) ecnt <= ecnt + 13'd1;
        end
        a_v <= pop;
        if (pop) begin
          a_emit <= pc >= 7'd7;
          a_x <= pc - 7'd7;
          a_r <= pr;
        end
        b_v <= a_v && a_emit;
        b_emit <= a_r >= 7'd7;
        b_x <= a_x;
        if (push) rwp <= rwp + 2'd1;
        if (grant[f]) rrp <= rrp + 2'd1;
        rcnt <= rcnt + 3'(push) - 3'(grant[f]);
      end
    end

    // Line buffer keeps the last 7 H values per column, oldest at [0]
    always_ff @(posedge clk) begin
      if (in_wr) fm[fwp] <= in_din[7:0];
      if (pop) begin
        for (int k = 0; k < 7; k++) hsr[k] <= hsr[k+1];
        hsr[7] <= fm[frp];
      end
      h_q <= hacc;
      if (b_v) begin
        for (int j = 0; j < 6; j++) lb[b_x][j] <= lb[b_x][j+1];
        lb[b_x][6] <= h_q;
      end
      if (push) rm[rwp] <= pix;
    end
  end

  assign req = res_req & ~out_full;

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int i = 1; i <= FLUX; i++) begin
      if (!found && req[(int'(last) + i) % FLUX]) begin
        found = 1'b1;
        grant[(int'(last) + i) % FLUX] = 1'b1;
        gid = TW'((int'(last) + i) % FLUX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_write <= 1'b0;
      out_din   <= '0;
      last      <= '0;
    end else begin
      out_write <= found;
      if (found) begin
        out_din <= {gid, res_head[gid]};
        last    <= gid;
      end
    end
  end
endmodule

// File: tb/tb_hevc_interp8_ms.sv
// tb_hevc_interp8_ms: randomized scoreboard bench for hevc_interp8_ms.
// Expected pixels come from a direct arithmetic model of the 8-tap filter.
module tb_hevc_interp8_ms;
  localparam int FLUX = 2;
  localparam int TW = 1;

  logic clk = 1'b0;
  logic rst;
  logic [TW+2:0] v_alpha_din, h_alpha_din;
  logic v_alpha_write, h_alpha_write;
  logic [FLUX-1:0] v_alpha_full, h_alpha_full, ext_size_full, in_full;
  logic [TW+6:0] ext_size_din;
  logic ext_size_write;
  logic [TW+7:0] in_din, out_din;
  logic in_write, out_write;
  logic [FLUX-1:0] out_full;

  always #5 clk = ~clk;

  hevc_interp8_ms dut (
    .clk(clk), .rst(rst),
    .v_alpha_din(v_alpha_din), .v_alpha_write(v_alpha_write),
    .v_alpha_full(v_alpha_full),
    .h_alpha_din(h_alpha_din), .h_alpha_write(h_alpha_write),
    .h_alpha_full(h_alpha_full),
    .ext_size_din(ext_size_din), .ext_size_write(ext_size_write),
    .ext_size_full(ext_size_full),
    .in_din(in_din), .in_write(in_write), .in_full(in_full),
    .out_din(out_din), .out_write(out_write), .out_full(out_full)
  );

  int checks = 0;
  int failures = 0;
  int exp_q [FLUX][$];
  int pq [FLUX][$];
  int n_out [FLUX];
  int cof [4][8] = '{'{0, 0, 0, 64, 0, 0, 0, 0},
                     '{-1, 4, -10, 58, 17, -5, 1, 0},
                     '{-1, 4, -11, 40, 40, -11, 4, -1},
                     '{0, 1, -5, 17, 58, -10, 4, -1}};

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  function automatic int cidx(input int a);
    return (a == 2) ? 1 : (a == 4) ? 2 : (a == 6) ? 3 : 0;
  endfunction

  always @(negedge clk) begin
    int t;
    int e;
    if (rst === 1'b0 && out_write === 1'b1) begin
      t = int'(out_din[8]);
      n_out[t]++;
      if (exp_q[t].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out flow=%0d actual=%0d required=none",
                 t, out_din[7:0]);
      end else begin
        e = exp_q[t].pop_front();
        check($sformatf("out_f%0d", t), int'(out_din[7:0]), e);
      end
    end
  end

  task automatic gen(input int f, input int mode, input int ext);
    int px;
    pq[f].delete();
    for (int r = 0; r < ext; r++)
      for (int c = 0; c < ext; c++) begin
        case (mode)
          0: px = (r * ext + c) % 256;
          1: px = 100;
          2: px = c;
          default: px = int'($urandom_range(0, 255));
        endcase
        pq[f].push_back(px);
      end
  endtask

  task automatic model(input int f, input int v, input int h, input int ext);
    int p [71][71];
    int sz, hs, vs, o, cv, ch;
    sz = ext - 7;
    cv = cidx(v);
    ch = cidx(h);
    for (int i = 0; i < ext * ext; i++) p[i / ext][i % ext] = pq[f][i];
    for (int y = 0; y < sz; y++)
      for (int x = 0; x < sz; x++) begin
        vs = 0;
        for (int r = 0; r < 8; r++) begin
          hs = 0;
          for (int k = 0; k < 8; k++) hs += cof[ch][k] * p[y+r][x+k];
          vs += cof[cv][r] * hs;
        end
        vs = vs >>> 6;
        o = (vs + 32) >>> 6;
        if (o < 0) o = 0;
        if (o > 255) o = 255;
        exp_q[f].push_back(o);
      end
  endtask

  task automatic cfg(input int f, input int v, input int h, input int ext);
    @(negedge clk);
    v_alpha_din = {f[0], v[2:0]};
    h_alpha_din = {f[0], h[2:0]};
    ext_size_din = {f[0], ext[6:0]};
    v_alpha_write = 1'b1;
    h_alpha_write = 1'b1;
    ext_size_write = 1'b1;
    @(negedge clk);
    v_alpha_write = 1'b0;
    h_alpha_write = 1'b0;
    ext_size_write = 1'b0;
  endtask

  task automatic block(input int f, input int v, input int h,
                       input int ext, input int mode);
    gen(f, mode, ext);
    model(f, v, h, ext);
    cfg(f, v, h, ext);
  endtask

  task automatic feed(input int gran);
    int cf, run, n, px, other;
    cf = 0; run = 0; n = 0;
    while ((pq[0].size() != 0 || pq[1].size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
      in_write = 1'b0;
      if (pq[cf].size() == 0 || run >= gran || in_full[cf]) begin
        other = 1 - cf;
        if (pq[other].size() != 0) begin
          cf = other;
          run = 0;
        end
      end
      if (pq[cf].size() != 0 && !in_full[cf]) begin
        px = pq[cf].pop_front();
        in_din = {cf[0], px[7:0]};
        in_write = 1'b1;
        run++;
      end
    end
    @(negedge clk);
    in_write = 1'b0;
    check("feed_timeout", pq[0].size() + pq[1].size(), 0);
    pq[0].delete();
    pq[1].delete();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, exp_q[0].size() + exp_q[1].size(), 0);
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic stall();
    int c0, c1, saw;
    @(negedge clk);
    out_full[1] = 1'b1;
    @(negedge clk);
    #1;
    c0 = n_out[0];
    c1 = n_out[1];
    saw = 0;
    repeat (500) begin
      @(negedge clk);
      #1;
      if (in_full[1]) saw = 1;
    end
    check("stall_no_tag1", n_out[1] - c1, 0);
    check("stall_flow0_moves", int'(n_out[0] > c0), 1);
    check("stall_in_full1", saw, 1);
    out_full[1] = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_out_write"}, int'(out_write), 0);
    check({tag, "_out_din"}, int'(out_din), 0);
    check({tag, "_v_full"}, int'(v_alpha_full), 0);
    check({tag, "_h_full"}, int'(h_alpha_full), 0);
    check({tag, "_ext_full"}, int'(ext_size_full), 0);
    check({tag, "_in_full"}, int'(in_full), 0);
  endtask

  initial begin
    int n, v, h, e0, e1;
    rst = 1'b1;
    v_alpha_din = '0; h_alpha_din = '0; ext_size_din = '0;
    v_alpha_write = 1'b0; h_alpha_write = 1'b0; ext_size_write = 1'b0;
    in_din = '0; in_write = 1'b0; out_full = '0;
    n_out[0] = 0;
    n_out[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    idle_checks("reset");

    block(0, 0, 0, 11, 0);
    #1;
    check("run_v_full0", int'(v_alpha_full[0]), 1);
    check("run_v_full1", int'(v_alpha_full[1]), 0);
    feed(24);
    wait_done("t1_ramp");

    for (int a = 0; a < 16; a++) begin
      block(a % 2, (a / 4) * 2, (a % 4) * 2, 23, 1);
      feed(24);
      wait_done($sformatf("t2_const_%0d", a));
    end

    block(1, 0, 4, 23, 2);
    feed(24);
    wait_done("t3_halfpel");

    block(0, 2, 2, 23, 3);
    block(1, 2, 2, 23, 3);
    feed(24);
    wait_done("t4_two_flows");

    block(0, 2, 2, 23, 3);
    block(1, 2, 2, 23, 3);
    fork
      feed(24);
      stall();
    join
    wait_done("t5_backpressure");

    @(negedge clk);
    ext_size_din = '0;
    ext_size_write = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("ext0_ignored", int'(ext_size_full[0]), 0);
    ext_size_din = {1'b0, 7'd72};
    @(negedge clk);
    #1;
    check("ext72_ignored", int'(ext_size_full[0]), 0);
    ext_size_din = {1'b0, 7'd7};
    @(negedge clk);
    #1;
    check("ext7_ignored", int'(ext_size_full[0]), 0);
    ext_size_write = 1'b0;
    block(0, 4, 2, 11, 3);
    ext_size_din = '0;
    ext_size_write = 1'b1;
    while (pq[0].size() > 100) void'(pq[0].pop_back());
    feed(24);
    n = 0;
    while (exp_q[0].size() > 8 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (5) @(negedge clk);
    #1;
    check("partial_remaining", exp_q[0].size(), 8);
    check("partial_running", int'(v_alpha_full[0]), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q[0].delete();
    exp_q[1].delete();
    rst = 1'b0;
    @(negedge clk);
    #1;
    idle_checks("midrst");
    repeat (3) @(negedge clk);
    #1;
    check("ext0_after_rst", int'(ext_size_full[0]), 0);
    ext_size_write = 1'b0;
    block(0, 6, 4, 11, 3);
    feed(16);
    wait_done("t6_fresh");

    block(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8, 3);
    block(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 71, 3);
    feed(int'($urandom_range(1, 40)));
    wait_done("t7_bounds");

    for (int it = 0; it < 4; it++) begin
      v = int'($urandom_range(0, 7));
      h = int'($urandom_range(0, 7));
      e0 = int'($urandom_range(8, 30));
      e1 = int'($urandom_range(8, 30));
      block(0, v, h, e0, 3);
      block(1, h, v, e1, 3);
      feed(int'($urandom_range(1, 50)));
      wait_done($sformatf("rand_%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
